// File: rtl/load_store_unit.sv
// Data-memory access stage: turns single-cycle load/store requests into a valid/ready
// bus transaction, stalls the core until completion and aligns/extends load data.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_enable,
    input  logic                  store_enable,
    input  logic [2:0]            func3,
    input  logic [3:0]            mem_write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  bus_error,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_write,
    output logic [31:0]           mem_req_wdata,
    output logic [3:0]            mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_rdata
);

    localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((RESP_TIMEOUT == 0) ? 0 : RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRequest,
        StResponse,
        StDone
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [2:0]              func3_q;
    logic [1:0]              lane_q;
    logic [CNT_W-1:0]        resp_cnt_q;
    logic                    req_valid_q;
    logic [31:0]             load_data_q;
    logic                    load_valid_q;
    logic                    misaligned_q;
    logic                    bus_error_q;

    logic                    start;
    logic                    misaligned_req;
    logic                    accept;
    logic [31:0]             wdata_rep;
    logic [3:0]              wstrb_shifted;
    logic [31:0]             lane_word;
    logic [31:0]             load_ext;

    assign start = load_enable | store_enable;

    always_comb begin
        misaligned_req = 1'b0;
        if (func3[1:0] == 2'b01 && address[0]) begin
            misaligned_req = 1'b1;
        end
        if (func3[1:0] == 2'b10 && address[1:0] != 2'b00) begin
            misaligned_req = 1'b1;
        end
    end

    assign accept = (state_q == StIdle) && start && !misaligned_req;

    // Reset gates stall so a held enable cannot leak through while in reset.
    assign stall = !reset &&
                   (accept || state_q == StRequest || state_q == StResponse);

    always_comb begin
        case (func3[1:0])
            2'b00:   wdata_rep = {4{store_data[7:0]}};
            2'b01:   wdata_rep = {2{store_data[15:0]}};
            default: wdata_rep = store_data;
        endcase
    end

    assign wstrb_shifted = store_enable ? (mem_write_enable << address[1:0]) : 4'b0000;

    assign lane_word = mem_resp_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (func3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_ext = {24'h000000, lane_word[7:0]};
            3'b101:  load_ext = {16'h0000, lane_word[15:0]};
            default: load_ext = mem_resp_rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            func3_q      <= '0;
            lane_q       <= '0;
            resp_cnt_q   <= '0;
            req_valid_q  <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (misaligned_req) begin
                            misaligned_q <= 1'b1;
                        end else begin
                            addr_q      <= {address[ADDR_WIDTH-1:2], 2'b00};
                            write_q     <= store_enable;
                            wdata_q     <= wdata_rep;
                            wstrb_q     <= wstrb_shifted;
                            func3_q     <= func3;
                            lane_q      <= address[1:0];
                            req_valid_q <= 1'b1;
                            state_q     <= StRequest;
                        end
                    end
                end
                StRequest: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        resp_cnt_q  <= '0;
                        state_q     <= write_q ? StDone : StResponse;
                    end
                end
                StResponse: begin
                    if (mem_resp_valid) begin
                        load_data_q  <= load_ext;
                        load_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end else if (RESP_TIMEOUT != 0 && resp_cnt_q == CNT_LAST) begin
                        bus_error_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        resp_cnt_q <= resp_cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    // Start is deliberately not sampled: the retiring instruction is still present.
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign load_data     = load_data_q;
    assign load_valid    = load_valid_q;
    assign misaligned    = misaligned_q;
    assign bus_error     = bus_error_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_write = write_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, multi-cycle corner
// sequences and randomized accesses against a behavioural model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_enable, store_enable;
    logic [2:0]  func3;
    logic [3:0]  mem_write_enable;
    logic [31:0] address, store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misaligned, bus_error;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_write;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_load = 32'h0;

    always #5 clock = ~clock;

    load_store_unit #(
        .ADDR_WIDTH  (32),
        .RESP_TIMEOUT(4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .load_enable     (load_enable),
        .store_enable    (store_enable),
        .func3           (func3),
        .mem_write_enable(mem_write_enable),
        .address         (address),
        .store_data      (store_data),
        .stall           (stall),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .misaligned      (misaligned),
        .bus_error       (bus_error),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_write   (mem_req_write),
        .mem_req_wdata   (mem_req_wdata),
        .mem_req_wstrb   (mem_req_wstrb),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          rdy;
        int          rsp;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] ld_data;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned a;
        a = addr;
        return (f3[1:0] == 2'b01 && a % 2 != 0) || (f3[1:0] == 2'b10 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int unsigned v;
        v = d;
        if (f3[1:0] == 2'b00) return (v % 256) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (v % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] w);
        int unsigned sh, b, h;
        sh = w >> (8 * (addr % 4));
        b = sh % 256;
        h = sh % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic access(input vec_t v);
        int  stalls, rcnt, hs, waited;
        bit  accepted, done, ld_eff;
        ld_eff   = v.ld && !v.st;
        stalls   = 1;
        rcnt     = 0;
        hs       = 0;
        waited   = 0;
        accepted = 0;
        done     = 0;
        @(negedge clock);
        check("idle_load_valid", {31'b0, load_valid}, 32'h0);
        check("hold_load_data", load_data, last_load);
        load_enable      = v.ld;
        store_enable     = v.st;
        func3            = v.f3;
        mem_write_enable = v.mask;
        address          = v.addr;
        store_data       = v.sdata;
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b0;
        #1;
        if (v.mis) begin
            check("mis_stall", {31'b0, stall}, 32'h0);
            @(negedge clock);
            load_enable  = 1'b0;
            store_enable = 1'b0;
            #1;
            check("mis_pulse", {31'b0, misaligned}, 32'h1);
            check("mis_no_req", {31'b0, mem_req_valid}, 32'h0);
            check("mis_stall_after", {31'b0, stall}, 32'h0);
            @(negedge clock);
            #1;
            check("mis_pulse_end", {31'b0, misaligned}, 32'h0);
            check("mis_no_req_later", {31'b0, mem_req_valid}, 32'h0);
            return;
        end
        check("start_stall", {31'b0, stall}, 32'h1);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
            #1;
            if (!stall) begin
                done = 1;
                check("stall_cycles", stalls, ld_eff ? 2 + v.rdy + v.rsp : 2 + v.rdy);
                check("handshakes", hs, 1);
                check("done_req_valid", {31'b0, mem_req_valid}, 32'h0);
                check("load_valid", {31'b0, load_valid}, {31'b0, ld_eff});
                if (ld_eff) begin
                    check("load_data", load_data, v.ld_data);
                    last_load = v.ld_data;
                end
                load_enable  = 1'b0;
                store_enable = 1'b0;
            end else begin
                stalls++;
                if (mem_req_valid) begin
                    check("req_addr", mem_req_addr, v.addr & 32'hFFFF_FFFC);
                    check("req_write", {31'b0, mem_req_write}, {31'b0, v.st});
                    check("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, v.wstrb});
                    if (v.st) check("req_wdata", mem_req_wdata, v.wdata);
                    if (waited == v.rdy) begin
                        mem_req_ready = 1'b1;
                        accepted      = 1;
                        hs++;
                    end
                    waited++;
                end else if (accepted && ld_eff) begin
                    rcnt++;
                    if (rcnt == v.rsp) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_rdata = v.rdata;
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: got stall still high expected completion");
            load_enable  = 1'b0;
            store_enable = 1'b0;
        end
    endtask

    initial begin
        int seen;
        vec_t r;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int   seen;
        vec_t r;
        logic [2:0] ld_codes[5];
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        tbl[0]  = '{1'b0, 1'b1, 3'b010, 4'hF, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0,
                    1'b0, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 3'b000, 4'h1, 32'h203, 32'h000000A5, 1, 1, 32'h0,
                    1'b0, 32'hA5A5A5A5, 4'h8, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'b000, 4'h1, 32'h302, 32'h0, 0, 2, 32'h00800000,
                    1'b0, 32'h0, 4'h0, 32'hFFFFFF80};
        tbl[3]  = '{1'b1, 1'b0, 3'b100, 4'h1, 32'h302, 32'h0, 0, 2, 32'h00800000,
                    1'b0, 32'h0, 4'h0, 32'h00000080};
        tbl[4]  = '{1'b0, 1'b1, 3'b010, 4'hF, 32'h040, 32'h12345678, 4, 1, 32'h0,
                    1'b0, 32'h12345678, 4'hF, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 3'b010, 4'hF, 32'h102, 32'h0, 0, 1, 32'h0,
                    1'b1, 32'h0, 4'h0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 3'b001, 4'h3, 32'h101, 32'h0, 0, 1, 32'h0,
                    1'b1, 32'h0, 4'h0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 3'b001, 4'h3, 32'h102, 32'h0, 0, 1, 32'h80010000,
                    1'b0, 32'h0, 4'h0, 32'hFFFF8001};
        tbl[8]  = '{1'b1, 1'b0, 3'b101, 4'h3, 32'h102, 32'h0, 1, 3, 32'h80010000,
                    1'b0, 32'h0, 4'h0, 32'h00008001};
        tbl[9]  = '{1'b0, 1'b1, 3'b001, 4'h3, 32'h006, 32'h1234BEEF, 0, 1, 32'h0,
                    1'b0, 32'hBEEFBEEF, 4'hC, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 3'b010, 4'hF, 32'h008, 32'h0BADF00D, 2, 1, 32'h0,
                    1'b0, 32'h0BADF00D, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 3'b000, 4'h0, 32'h011, 32'h0000003C, 0, 1, 32'h0,
                    1'b0, 32'h3C3C3C3C, 4'h0, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 3'b010, 4'hF, 32'h200, 32'h0, 2, 1, 32'hCAFEF00D,
                    1'b0, 32'h0, 4'h0, 32'hCAFEF00D};
        tbl[13] = '{1'b1, 1'b0, 3'b011, 4'hF, 32'h013, 32'h0, 0, 2, 32'h87654321,
                    1'b0, 32'h0, 4'h0, 32'h87654321};
        tbl[14] = '{1'b0, 1'b1, 3'b010, 4'hF, 32'h101, 32'h55AA55AA, 0, 1, 32'h0,
                    1'b1, 32'h0, 4'h0, 32'h0};

        reset            = 1'b1;
        load_enable      = 1'b0;
        store_enable     = 1'b0;
        func3            = 3'b000;
        mem_write_enable = 4'h0;
        address          = 32'h0;
        store_data       = 32'h0;
        mem_req_ready    = 1'b0;
        mem_resp_valid   = 1'b0;
        mem_resp_rdata   = 32'h0;

        // Reset state, including with a load request held at the inputs.
        @(negedge clock);
        load_enable = 1'b1;
        #1;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_load_valid", {31'b0, load_valid}, 32'h0);
        check("rst_flags", {30'b0, misaligned, bus_error}, 32'h0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_req_fields", {mem_req_wdata[27:0], mem_req_wstrb}, 32'h0);
        load_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) access(tbl[i]);

        // A stray response while idle must not disturb load_data.
        @(negedge clock);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        mem_resp_valid = 1'b0;
        #1;
        check("stray_resp_valid", {31'b0, load_valid}, 32'h0);
        check("stray_resp_data", load_data, last_load);

        // Response timeout: four RESPONSE cycles then a bus_error pulse.
        @(negedge clock);
        load_enable      = 1'b1;
        store_enable     = 1'b0;
        func3            = 3'b010;
        mem_write_enable = 4'hF;
        address          = 32'h88;
        mem_req_ready    = 1'b1;
        seen             = 0;
        for (int n = 1; n <= 20 && seen == 0; n++) begin
            @(negedge clock);
            if (n == 2) mem_req_ready = 1'b0;
            #1;
            if (bus_error) seen = n;
        end
        check("timeout_cycle", seen, 6);
        check("timeout_load_valid", {31'b0, load_valid}, 32'h0);
        check("timeout_req_valid", {31'b0, mem_req_valid}, 32'h0);
        load_enable = 1'b0;
        @(negedge clock);
        #1;
        check("timeout_pulse_end", {31'b0, bus_error}, 32'h0);
        check("timeout_idle_stall", {31'b0, stall}, 32'h0);
        check("timeout_load_data", load_data, last_load);

        // Reset while waiting in RESPONSE clears every output at once.
        @(negedge clock);
        load_enable   = 1'b1;
        address       = 32'h84;
        mem_req_ready = 1'b1;
        @(negedge clock);
        #1;
        check("rr_req_valid", {31'b0, mem_req_valid}, 32'h1);
        @(negedge clock);
        mem_req_ready = 1'b0;
        #1;
        check("rr_wait_stall", {31'b0, stall}, 32'h1);
        reset = 1'b1;
        #1;
        check("rr_stall", {31'b0, stall}, 32'h0);
        check("rr_req_valid_drop", {31'b0, mem_req_valid}, 32'h0);
        check("rr_load_data", load_data, 32'h0);
        check("rr_req_addr", mem_req_addr, 32'h0);
        check("rr_outputs", {28'b0, load_valid, misaligned, bus_error, mem_req_write}, 32'h0);
        @(negedge clock);
        load_enable = 1'b0;
        reset       = 1'b0;
        last_load   = 32'h0;

        // Randomized accesses against the behavioural model.
        for (int k = 0; k < 40; k++) begin
            r.st = $urandom_range(0, 1);
            r.ld = !r.st || ($urandom_range(0, 7) == 0);
            if (r.st) r.f3 = 3'($urandom_range(0, 2));
            else      r.f3 = ld_codes[$urandom_range(0, 4)];
            r.mask    = (r.f3[1:0] == 2'b00) ? 4'h1 : (r.f3[1:0] == 2'b01) ? 4'h3 : 4'hF;
            r.addr    = $urandom & 32'h0000_FFFF;
            r.sdata   = $urandom;
            r.rdata   = $urandom;
            r.rdy     = $urandom_range(0, 3);
            r.rsp     = $urandom_range(1, 3);
            r.mis     = model_mis(r.f3, r.addr);
            r.wdata   = model_wdata(r.f3, r.sdata);
            r.wstrb   = r.st ? 4'((r.mask * (1 << (r.addr % 4))) % 16) : 4'h0;
            r.ld_data = model_load(r.f3, r.addr, r.rdata);
            access(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
